wb_split_n: RTL



---
 rtl/wb_split_n.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wb_split_n.sv
// Wishbone classic 1-to-NS splitter with a per-access watchdog and error termination.
// Optional error logging (err_adr_o / err_cnt_o) is enabled by defining WB_SPLIT_ERR_LOG_EN.
module wb_split_n #(
    parameter int          NS       = 4,
    parameter int          SEL_LSB  = 16,
    parameter int          SEL_W    = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] DEF_DATA = 32'hDEADBEEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      adr_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic             s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*32-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    input  logic             err_clr_i,
    output logic             err_irq
`ifdef WB_SPLIT_ERR_LOG_EN
    ,
    output logic [31:0]      err_adr_o,
    output logic [7:0]       err_cnt_o
`endif
);

    localparam int             IW    = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [SEL_W:0] NS_L  = NS[SEL_W:0];
    localparam logic [15:0]    WD_LIM = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ERR
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     wd_q, wd_d;
    logic            err_q, err_d;
    logic [SEL_W-1:0] idx;
    logic            mapped;
    logic            err_entry;
    logic            hit_ack;
    logic [31:0]     hit_dat;

    // Write-side signals go straight to the slaves; only the fold keeps them referenced.
    logic unused_ok;
    assign unused_ok = ^{we_i, sel_i, dat_i, adr_i};

    assign idx     = adr_i[SEL_LSB +: SEL_W];
    assign mapped  = ({1'b0, idx} < NS_L);
    assign err_irq = err_q;

    always_comb begin
        hit_ack = 1'b0;
        hit_dat = '0;
        for (int k = 0; k < NS; k++) begin
            if (idx_q == IW'(k)) begin
                hit_ack = s_ack_i[k];
                hit_dat = s_dat_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wd_d      = wd_q;
        err_entry = 1'b0;
        ack_o     = 1'b0;
        dat_o     = '0;
        s_cyc_o   = 1'b0;
        s_stb_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    if (mapped) begin
                        idx_d   = idx[IW-1:0];
                        wd_d    = '0;
                        state_d = ACTIVE;
                    end else begin
                        state_d   = ERR;
                        err_entry = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                s_cyc_o = cyc_i;
                for (int k = 0; k < NS; k++) begin
                    s_stb_o[k] = stb_i && (idx_q == IW'(k));
                end
                ack_o = hit_ack;
                dat_o = hit_dat;
                // Ack beats the watchdog limit when both land together.
                if (hit_ack || !cyc_i) begin
                    state_d = IDLE;
                end else if (wd_q >= WD_LIM) begin
                    state_d   = ERR;
                    err_entry = 1'b1;
                end else if (wd_q != 16'hFFFF) begin
                    wd_d = wd_q + 16'd1;
                end
            end
            ERR: begin
                ack_o   = 1'b1;
                dat_o   = DEF_DATA;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (state_q == ERR) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

`ifdef WB_SPLIT_ERR_LOG_EN
    logic [31:0] err_adr_q, err_adr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        err_adr_d = err_adr_q;
        err_cnt_d = err_clr_i ? 8'd0 : err_cnt_q;
        if (err_entry) begin
            err_adr_d = adr_i;
            if (err_cnt_d != 8'hFF) begin
                err_cnt_d = err_cnt_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_adr_q <= '0;
            err_cnt_q <= '0;
        end else begin
            err_adr_q <= err_adr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_adr_o = err_adr_q;
    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err_entry;
    assign unused_err_entry = err_entry;
`endif

endmodule
